// File: rtl/acc_pkg.sv
// Shared types and sizing helpers for the accumulation-chain receive controller.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } rx_state_t;

   localparam int DEFAULT_DEPTH = 16;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/acc_receive_ctrl_idx_counter.sv
// Beat index counter: clears on burst start/abort, counts accepted beats,
// and flags the terminal beat (idx == len_q).
module idx_counter
   import acc_pkg::*;
#(
   parameter int ADDR_W = addr_w(DEFAULT_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [ADDR_W-1:0] len_q,
   output logic [ADDR_W-1:0] idx,
   output logic              tc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         idx <= '0;
      end else if (en) begin
         idx <= idx + 1'b1;
      end
   end

   assign tc = (idx == len_q);

endmodule

// File: rtl/acc_receive_ctrl.sv
// Receive-side controller for a PE in the accumulation chain: takes a burst of
// beats over valid/ready and turns them into local-buffer write strobes/addresses.
module acc_receive_ctrl
   import acc_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] burst_len,
   input  logic              buf_empty,
   input  logic              abort,
   input  logic              acc_valid_in,
   input  logic              wr_ready,
   output logic              acc_ready_out,
   output logic              receive_write,
   output logic [ADDR_W-1:0] receive_addr,
   output logic              busy,
   output logic              rx_done
);

   rx_state_t         state;
   rx_state_t         state_n;
   logic              pending;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] idx;
   logic              tc;
   logic              idx_clr;
   logic              idx_en;
   logic              go;
   logic              beat;

   assign go   = (pending | start) & buf_empty;
   assign beat = acc_valid_in & wr_ready;

   idx_counter #(
      .ADDR_W (ADDR_W)
   ) u_idx (
      .clk   (clk),
      .rst   (rst),
      .clr   (idx_clr),
      .en    (idx_en),
      .len_q (len_q),
      .idx   (idx),
      .tc    (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Ready/strobe stay combinational so a stalled beat is never lost or duplicated.
   always_comb begin
      state_n       = state;
      acc_ready_out = 1'b0;
      receive_write = 1'b0;
      rx_done       = 1'b0;
      idx_clr       = 1'b0;
      idx_en        = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               state_n = RECV;
               idx_clr = 1'b1;
            end
         end
         RECV: begin
            acc_ready_out = wr_ready;
            receive_write = beat;
            if (beat) begin
               if (tc) begin
                  state_n = DONE;
               end else begin
                  idx_en = 1'b1;
               end
            end
         end
         DONE: begin
            rx_done = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (abort) begin
         state_n = IDLE;
         idx_clr = 1'b1;
         idx_en  = 1'b0;
         rx_done = 1'b0;
      end
   end

   // A start seen while waiting on buf_empty is remembered; repeats are ignored.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         pending <= 1'b0;
      end else if (state == IDLE) begin
         pending <= go ? 1'b0 : (pending | start);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q <= '0;
      end else if ((state == IDLE) && go && !abort) begin
         len_q <= burst_len;
      end
   end

   assign receive_addr = idx;
   assign busy         = pending | (state != IDLE);

endmodule

// File: tb/tb_acc_receive_ctrl.sv
// Scoreboard bench for acc_receive_ctrl (DEPTH=8): expected write addresses are
// queued when a burst is launched and popped as the DUT strobes writes.
module tb_acc_receive_ctrl;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] burst_len = '0;
   logic              buf_empty = 1'b1;
   logic              abort = 1'b0;
   logic              acc_valid_in = 1'b0;
   logic              wr_ready = 1'b0;
   logic              acc_ready_out;
   logic              receive_write;
   logic [ADDR_W-1:0] receive_addr;
   logic              busy;
   logic              rx_done;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   logic [ADDR_W-1:0] exp_q[$];

   acc_receive_ctrl #(
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .burst_len     (burst_len),
      .buf_empty     (buf_empty),
      .abort         (abort),
      .acc_valid_in  (acc_valid_in),
      .wr_ready      (wr_ready),
      .acc_ready_out (acc_ready_out),
      .receive_write (receive_write),
      .receive_addr  (receive_addr),
      .busy          (busy),
      .rx_done       (rx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the next queued address.
   always @(negedge clk) begin
      if (receive_write) begin
         wr_cnt++;
         if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
         else check("wr_addr", {29'd0, receive_addr}, {29'd0, exp_q.pop_front()});
      end
      if (rx_done) done_cnt++;
   end

   // Called at posedge+1 of the first RECV cycle; returns at the negedge after rx_done+1.
   task automatic wait_done(input int len, input logic [31:0] mask);
      int t;
      int w0;
      int lows;
      bit got;
      t = 0; w0 = wr_cnt; lows = 0; got = 0;
      while (!got && t < 40) begin
         wr_ready = (t < 32) ? !mask[t] : 1'b1;
         @(negedge clk); #1;
         if (rx_done) begin
            got = 1;
            check("rdy_in_done", {31'd0, acc_ready_out}, 0);
         end else begin
            check("rdy_follows_wr", {31'd0, acc_ready_out}, {31'd0, wr_ready});
            if (!acc_ready_out) lows++;
            @(posedge clk); #1;
            t++;
         end
      end
      wr_ready = 1'b1;
      check("done_seen", {31'd0, got}, 1);
      check("n_writes", wr_cnt - w0, len + 1);
      check("done_cycle", t, len + 1 + $countones(mask));
      check("stall_cycles", lows, $countones(mask));
      @(posedge clk); #1;
      @(negedge clk);
      check("busy_after", {31'd0, busy}, 0);
      check("done_one_cycle", {31'd0, rx_done}, 0);
   endtask

   task automatic burst(input logic [ADDR_W-1:0] len, input logic [31:0] mask);
      @(posedge clk); #1;
      start = 1'b1; burst_len = len; buf_empty = 1'b1;
      acc_valid_in = 1'b1; wr_ready = 1'b1;
      for (int k = 0; k <= int'(len); k++) exp_q.push_back(ADDR_W'(k));
      @(negedge clk);
      check("start_cycle_rdy", {31'd0, acc_ready_out}, 0);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(int'(len), mask);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("idle_outputs", {27'd0, acc_ready_out, receive_write, receive_addr, busy, rx_done}, 0);
      end

      // Full-throughput 4-beat burst
      burst(3'd3, 32'h0);

      // 8 beats with two 2-cycle stalls (before beats 2 and 5)
      burst(3'd7, 32'h0000_018C);

      // Deferred start waiting on buf_empty, with an ignored second start
      @(posedge clk); #1;
      start = 1'b1; burst_len = 3'd2; buf_empty = 1'b0; acc_valid_in = 1'b1; wr_ready = 1'b1;
      for (int k = 0; k <= 2; k++) exp_q.push_back(ADDR_W'(k));
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         start     = (c == 3);
         burst_len = (c == 3) ? 3'd7 : 3'd2;
         buf_empty = (c == 6);
         @(negedge clk);
         check("wait_busy", {31'd0, busy}, 1);
         check("wait_rdy", {31'd0, acc_ready_out}, 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2, 32'h0);

      // Abort after the write at addr 2
      @(posedge clk); #1;
      start = 1'b1; burst_len = 3'd5; buf_empty = 1'b1; acc_valid_in = 1'b1; wr_ready = 1'b1;
      for (int k = 0; k <= 2; k++) exp_q.push_back(ADDR_W'(k));
      @(posedge clk); #1 start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      abort = 1'b1; acc_valid_in = 1'b0;
      @(negedge clk);
      check("abort_cycle_done", {31'd0, rx_done}, 0);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_rdy", {31'd0, acc_ready_out}, 0);
      repeat (2) @(posedge clk);
      check("abort_no_done", done_cnt, 3);
      acc_valid_in = 1'b1;
      burst(3'd0, 32'h0);

      // Abort and start together in IDLE: abort wins, nothing pending
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; buf_empty = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("abort_start_busy", {31'd0, busy}, 0);
      @(posedge clk); #1 buf_empty = 1'b1;
      @(negedge clk);
      check("abort_start_stays_idle", {31'd0, busy}, 0);

      // Reset mid-burst at addr 4
      @(posedge clk); #1;
      start = 1'b1; burst_len = 3'd7; acc_valid_in = 1'b1; wr_ready = 1'b1;
      for (int k = 0; k <= 4; k++) exp_q.push_back(ADDR_W'(k));
      @(posedge clk); #1 start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {27'd0, acc_ready_out, receive_write, receive_addr, busy, rx_done}, 0);
      burst(3'd4, 32'h0);

      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("done_total", done_cnt, 5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
